// File: rtl/mac_bus_pkg.sv
// Shared memory-bus definitions for the slot arbiter and its clients.
// Holds the default slot timing (phases per slot, request latch phase,
// first data-valid phase), the fixed channel indices, and the slot
// classification used when the owner of the next slot is decided.
package mac_bus_pkg;

   localparam int BUS_PHASES      = 8;
   localparam int BUS_LATCH_PHASE = 2;
   localparam int BUS_DONE_PHASE  = 4;

   localparam int CH_VIDEO = 0;
   localparam int CH_SOUND = 1;
   localparam int CH_CPU   = 2;
   localparam int CH_DMA   = 3;

   // Video and sound must never miss a slot, so they bypass round-robin.
   localparam logic [3:0] BUS_RT_MASK = 4'((1 << CH_VIDEO) | (1 << CH_SOUND));

   typedef enum logic [1:0] {
      SLOT_IDLE = 2'd0,
      SLOT_RT   = 2'd1,
      SLOT_RR   = 2'd2
   } slot_kind_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker.
// Searches (req & mask) starting at index ptr and wrapping upward, and
// returns the first hit as a one-hot grant plus its binary index.
// Ports:
//   req     in  N   candidate requests
//   mask    in  N   channels allowed to take part
//   ptr     in  PW  highest-priority index for this pick
//   gnt     out N   one-hot winner (zero when nothing is eligible)
//   gnt_idx out PW  binary index of the winner
//   any     out 1   a winner exists
module rr_pick #(
   parameter int N  = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [N-1:0]  mask,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] gnt_idx,
   output logic          any
);

   always_comb begin
      int idx;
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      idx     = 0;
      for (int off = 0; off < N; off++) begin
         idx = (int'(ptr) + off) % N;
         if (!any && req[idx] && mask[idx]) begin
            gnt[idx] = 1'b1;
            gnt_idx  = PW'(idx);
            any      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_slot_arbiter.sv
// Time-slotted memory bus arbiter.
// A slot is PHASES clk8 enables long. Requests are sampled at LATCH_PHASE
// and must still be present at the wrap to phase 0, where the owner of the
// new slot is chosen: real-time channels by fixed priority (lowest index),
// otherwise round-robin among the remaining channels. Grant and the memory
// strobes/address are frozen for the whole slot; ack is the live request
// gated by grant from DONE_PHASE onward.
// Ports:
//   clk_sys   in  1        system clock
//   RESET     in  1        synchronous active-high reset
//   clk8_en_p in  1        phase-advance enable
//   req       in  NCH      per-channel request level
//   req_we    in  NCH      per-channel write flag
//   req_addr  in  NCH*AW   per-channel word address (channel i at [i*AW +: AW])
//   grant     out NCH      one-hot slot owner
//   ack       out NCH      per-channel completion
//   busPhase  out log2(PHASES) current phase
//   mem_addr  out AW       memory address for the slot
//   mem_oe    out 1        read strobe for the slot
//   mem_we    out 1        write strobe for the slot
module bus_slot_arbiter
   import mac_bus_pkg::*;
#(
   parameter int               NCH         = 4,
   parameter int               PHASES      = BUS_PHASES,
   parameter int               LATCH_PHASE = BUS_LATCH_PHASE,
   parameter int               DONE_PHASE  = BUS_DONE_PHASE,
   parameter logic [NCH-1:0]   RT_MASK     = BUS_RT_MASK,
   parameter int               AW          = 21
) (
   input  logic                        clk_sys,
   input  logic                        RESET,
   input  logic                        clk8_en_p,
   input  logic [NCH-1:0]              req,
   input  logic [NCH-1:0]              req_we,
   input  logic [NCH*AW-1:0]           req_addr,
   output logic [NCH-1:0]              grant,
   output logic [NCH-1:0]              ack,
   output logic [$clog2(PHASES)-1:0]   busPhase,
   output logic [AW-1:0]               mem_addr,
   output logic                        mem_oe,
   output logic                        mem_we
);

   localparam int PW = $clog2(PHASES);
   localparam int CW = $clog2(NCH);

   function automatic int first_nonrt(input logic [NCH-1:0] m);
      int r;
      r = 0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (!m[i]) r = i;
      end
      return r;
   endfunction

   localparam logic [CW-1:0] PTR_RST = CW'(first_nonrt(RT_MASK));

   logic [PW-1:0]  phase_q, phase_d;
   logic [NCH-1:0] qual_q, qual_d;
   logic [NCH-1:0] grant_q, grant_d;
   logic [CW-1:0]  ptr_q, ptr_d;
   logic [AW-1:0]  mem_addr_q, mem_addr_d;
   logic           mem_oe_q, mem_oe_d;
   logic           mem_we_q, mem_we_d;

   logic           at_latch, at_wrap;
   logic [NCH-1:0] cand, rt_cand, rt_gnt, rr_gnt, win_gnt;
   logic [CW-1:0]  rr_idx;
   logic           rr_any;
   logic [AW-1:0]  win_addr;
   logic           win_we;
   slot_kind_e     slot_kind;

   rr_pick #(.N(NCH)) u_rr_pick (
      .req     (cand),
      .mask    (~RT_MASK),
      .ptr     (ptr_q),
      .gnt     (rr_gnt),
      .gnt_idx (rr_idx),
      .any     (rr_any)
   );

   always_comb begin
      at_latch = clk8_en_p && (phase_q == PW'(LATCH_PHASE));
      at_wrap  = clk8_en_p && (phase_q == PW'(PHASES - 1));
      cand     = qual_q & req;
      rt_cand  = cand & RT_MASK;
      // x & -x isolates the lowest set bit: fixed priority to the lowest index.
      rt_gnt   = rt_cand & (~rt_cand + NCH'(1));

      if (rt_cand != '0)  slot_kind = SLOT_RT;
      else if (rr_any)    slot_kind = SLOT_RR;
      else                slot_kind = SLOT_IDLE;

      case (slot_kind)
         SLOT_RT: win_gnt = rt_gnt;
         SLOT_RR: win_gnt = rr_gnt;
         default: win_gnt = '0;
      endcase

      win_addr = '0;
      win_we   = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (win_gnt[i]) begin
            win_addr = req_addr[i*AW +: AW];
            win_we   = req_we[i];
         end
      end
   end

   always_comb begin
      phase_d    = phase_q;
      qual_d     = qual_q;
      grant_d    = grant_q;
      ptr_d      = ptr_q;
      mem_addr_d = mem_addr_q;
      mem_oe_d   = mem_oe_q;
      mem_we_d   = mem_we_q;

      if (clk8_en_p) phase_d = phase_q + PW'(1);

      if (at_latch) qual_d = req;

      if (at_wrap) begin
         qual_d   = '0;
         grant_d  = win_gnt;
         mem_oe_d = (slot_kind != SLOT_IDLE) && !win_we;
         mem_we_d = (slot_kind != SLOT_IDLE) && win_we;
         // An idle slot keeps the previous address on the bus.
         if (slot_kind != SLOT_IDLE) mem_addr_d = win_addr;
         if (slot_kind == SLOT_RR) begin
            ptr_d = (int'(rr_idx) == NCH - 1) ? '0 : rr_idx + CW'(1);
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (RESET) begin
         phase_q    <= '0;
         qual_q     <= '0;
         grant_q    <= '0;
         ptr_q      <= PTR_RST;
         mem_addr_q <= '0;
         mem_oe_q   <= 1'b0;
         mem_we_q   <= 1'b0;
      end else begin
         phase_q    <= phase_d;
         qual_q     <= qual_d;
         grant_q    <= grant_d;
         ptr_q      <= ptr_d;
         mem_addr_q <= mem_addr_d;
         mem_oe_q   <= mem_oe_d;
         mem_we_q   <= mem_we_d;
      end
   end

   assign grant    = grant_q;
   assign busPhase = phase_q;
   assign mem_addr = mem_addr_q;
   assign mem_oe   = mem_oe_q;
   assign mem_we   = mem_we_q;
   // Gated by RESET so ack drops in the same cycle reset is raised.
   assign ack      = grant_q & req & {NCH{(phase_q >= PW'(DONE_PHASE)) && !RESET}};

endmodule

// File: tb/tb_bus_slot_arbiter.sv
module tb_bus_slot_arbiter;

   localparam int NCH    = 4;
   localparam int AW     = 21;
   localparam int PHASES = 8;
   localparam int LATCH  = 2;
   localparam int DONE   = 4;
   localparam int PW     = 3;
   localparam logic [NCH-1:0] RTM = 4'b0011;

   logic              clk_sys   = 1'b0;
   logic              RESET     = 1'b1;
   logic              clk8_en_p = 1'b0;
   logic [NCH-1:0]    req       = '0;
   logic [NCH-1:0]    req_we    = '0;
   logic [NCH*AW-1:0] req_addr  = '0;
   logic [NCH-1:0]    grant, ack;
   logic [PW-1:0]     busPhase;
   logic [AW-1:0]     mem_addr;
   logic              mem_oe, mem_we;

   bus_slot_arbiter dut (
      .clk_sys   (clk_sys),
      .RESET     (RESET),
      .clk8_en_p (clk8_en_p),
      .req       (req),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .grant     (grant),
      .ack       (ack),
      .busPhase  (busPhase),
      .mem_addr  (mem_addr),
      .mem_oe    (mem_oe),
      .mem_we    (mem_we)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct {
      int             phase;
      logic [NCH-1:0] grant;
      logic [NCH-1:0] ack;
      logic           oe;
      logic           we;
      logic [AW-1:0]  addr;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   done     = 1'b0;

   // Reference model state: slot-level view of the bus.
   int            m_phase = 0;
   int            m_owner = -1;
   int            m_last  = 1;
   bit            m_qual[NCH];
   logic          m_oe = 1'b0, m_we = 1'b0;
   logic [AW-1:0] m_addr = '0;

   logic [NCH-1:0]    s_req  = '0;
   logic [NCH-1:0]    s_we   = '0;
   logic [NCH*AW-1:0] s_addr = '0;

   function automatic int reset_last();
      int f;
      f = -1;
      for (int i = 0; i < NCH; i++) if (f < 0 && !RTM[i]) f = i;
      return (f + NCH - 1) % NCH;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit en, input bit rst);
      exp_t e;
      int   win;
      if (rst) begin
         m_phase = 0;
         m_owner = -1;
         m_last  = reset_last();
         foreach (m_qual[i]) m_qual[i] = 1'b0;
         m_oe = 1'b0; m_we = 1'b0; m_addr = '0;
      end else if (en) begin
         if (m_phase == LATCH) begin
            for (int i = 0; i < NCH; i++) m_qual[i] = s_req[i];
         end else if (m_phase == PHASES - 1) begin
            win = -1;
            for (int i = 0; i < NCH; i++)
               if (win < 0 && RTM[i] && m_qual[i] && s_req[i]) win = i;
            if (win < 0) begin
               for (int k = 1; k <= NCH; k++) begin
                  int c;
                  c = (m_last + k) % NCH;
                  if (win < 0 && !RTM[c] && m_qual[c] && s_req[c]) win = c;
               end
               if (win >= 0) m_last = win;
            end
            m_owner = win;
            if (win >= 0) begin
               m_addr = s_addr[win*AW +: AW];
               m_we   = s_we[win];
               m_oe   = !s_we[win];
            end else begin
               m_we = 1'b0;
               m_oe = 1'b0;
            end
            foreach (m_qual[i]) m_qual[i] = 1'b0;
         end
         m_phase = (m_phase + 1) % PHASES;
      end
      e.phase = m_phase;
      e.grant = '0;
      e.ack   = '0;
      if (m_owner >= 0) begin
         e.grant[m_owner] = 1'b1;
         e.ack[m_owner]   = s_req[m_owner] && (m_phase >= DONE) && !rst;
      end
      e.oe   = m_oe;
      e.we   = m_we;
      e.addr = m_addr;
      exp_q.push_back(e);
   endtask

   task automatic step(input bit en, input bit rst);
      @(negedge clk_sys);
      clk8_en_p = en;
      RESET     = rst;
      req       = s_req;
      req_we    = s_we;
      req_addr  = s_addr;
      model_step(en, rst);
   endtask

   task automatic run_to_phase(input int ph);
      int guard;
      guard = 0;
      while (m_phase != ph && guard < 64) begin
         step(1'b1, 1'b0);
         guard++;
      end
   endtask

   // Monitor: one expected record per clock, compared just after the edge.
   initial begin
      exp_t e;
      while (!done) begin
         @(posedge clk_sys);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("busPhase", 32'(busPhase), 32'(e.phase));
            check("grant",    32'(grant),    32'(e.grant));
            check("ack",      32'(ack),      32'(e.ack));
            check("mem_oe",   32'(mem_oe),   32'(e.oe));
            check("mem_we",   32'(mem_we),   32'(e.we));
            check("mem_addr", 32'(mem_addr), 32'(e.addr));
         end
      end
   end

   initial begin
      int guard;
      m_last = reset_last();
      repeat (3) step(1'b0, 1'b1);

      // Video + CPU from phase 0: video wins, CPU must not see ack.
      s_req = 4'b0101;
      repeat (2 * PHASES) step(1'b1, 1'b0);
      s_req = '0;
      repeat (2 * PHASES) step(1'b1, 1'b0);

      // CPU and DMA both pending: grants alternate.
      s_req = 4'b1100;
      repeat (4 * PHASES) step(1'b1, 1'b0);
      s_req = '0;
      repeat (PHASES) step(1'b1, 1'b0);

      // Late request at phase 3 waits an extra slot.
      run_to_phase(3);
      s_req = 4'b0100;
      repeat (3 * PHASES) step(1'b1, 1'b0);
      s_req = '0;
      repeat (PHASES) step(1'b1, 1'b0);

      // DMA write dropped at phase 5: strobes and address held.
      s_req = 4'b1000; s_we = 4'b1000;
      s_addr[3*AW +: AW] = 21'h1ABCD;
      guard = 0;
      while (!(m_owner == 3 && m_phase == 5) && guard < 64) begin
         step(1'b1, 1'b0);
         guard++;
      end
      s_req = '0;
      repeat (2 * PHASES) step(1'b1, 1'b0);

      // Reset at phase 5 of a granted slot.
      s_req = 4'b0010; s_we = '0;
      guard = 0;
      while (!(m_owner == 1 && m_phase == 5) && guard < 64) begin
         step(1'b1, 1'b0);
         guard++;
      end
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      repeat (2 * PHASES) step(1'b1, 1'b0);

      // Phase enable stalled mid-slot.
      s_req = 4'b0001;
      guard = 0;
      while (!(m_owner == 0 && m_phase == 5) && guard < 64) begin
         step(1'b1, 1'b0);
         guard++;
      end
      repeat (10) step(1'b0, 1'b0);
      repeat (PHASES) step(1'b1, 1'b0);

      // Randomised traffic.
      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < NCH; i++) begin
            if ($urandom_range(15) == 0) begin
               s_req[i] = ~s_req[i];
               s_we[i]  = 1'($urandom_range(1));
               s_addr[i*AW +: AW] = AW'($urandom);
            end
            if ($urandom_range(40) == 0) s_we[i] = ~s_we[i];
         end
         step($urandom_range(2) != 0, $urandom_range(500) == 0);
      end

      repeat (2) @(posedge clk_sys);
      #2;
      done = 1'b1;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
